ip_cdc_arb: RTL and testbench
=============================

IP_CDC_ARB -- requirements
Module: ip_cdc_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one handshake CDC channel (2..8).
REQ-002 Parameter DATAWIDTH, default 32: payload width per requester and on the channel.
REQ-003 Parameter HOLD_CYCLES, default 16: idle cycles enforced after each launch; it SHALL exceed the channel's full lock/release round trip.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, on ports clock and reset.
REQ-005 Port clock, input, 1: source-domain clock; all state updates on posedge.
REQ-006 Port reset, input, 1: asynchronous active-low reset.
REQ-007 Port enable, input, 1: grants allowed while high.
REQ-008 Port reqValid, input, NUM_REQ: per-requester request; bit i belongs to requester i.
REQ-009 Port reqData, input, NUM_REQ*DATAWIDTH: requester i payload at bits [i*DATAWIDTH +: DATAWIDTH].
REQ-010 Port reqReady, output, NUM_REQ: one-cycle, one-hot acceptance pulse per requester.
REQ-011 Port cdcValid, output, 1: one-cycle launch pulse to the CDC channel's source-side valid.
REQ-012 Port cdcData, output, DATAWIDTH: payload to the CDC channel, held stable until the next launch.
REQ-013 Port busy, output, 1: high in ISSUE and WAIT.
REQ-014 Port grantId, output, clog2(NUM_REQ): index of the last granted requester, held until the next grant.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE and WAIT, and SHALL reset to IDLE.
REQ-016 In IDLE with enable=1 and any reqValid bit set, the block SHALL select winner g by round-robin at the clock edge, latch reqData[g] into cdcData, latch g into grantId, and go to ISSUE.
REQ-017 Round-robin: the search SHALL start at pointer p and ascend modulo NUM_REQ; after a grant to g, p SHALL become (g+1) mod NUM_REQ.
REQ-018 In ISSUE (exactly one cycle), cdcValid=1 and reqReady[g]=1; all other reqReady bits SHALL be 0; the next state SHALL be WAIT with the counter loaded to HOLD_CYCLES-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL return to IDLE; the counter SHALL never wrap.
REQ-020 Latency: with reqValid sampled high in IDLE at edge k, cdcValid and reqReady SHALL be high in cycle k+1.
REQ-021 The minimum spacing between consecutive cdcValid pulses SHALL be HOLD_CYCLES+2 cycles (ISSUE, HOLD_CYCLES WAIT cycles, then one IDLE cycle).
REQ-022 Requester protocol: reqValid and reqData are held until reqReady is seen; the transfer completes in the reqReady cycle.
REQ-023 A requester that drops reqValid during ISSUE or WAIT SHALL be ignored; its already-latched data is still launched.
REQ-024 enable=0 SHALL only block the IDLE-to-ISSUE transition; an in-flight ISSUE/WAIT sequence SHALL complete.
REQ-025 Simultaneous requests SHALL produce exactly one grant per launch; no requester SHALL wait more than NUM_REQ-1 grants while continuously requesting.
REQ-026 cdcValid and reqReady SHALL be registered outputs with no combinational path from reqValid.

Reset
REQ-027 On reset low, regardless of state, the block SHALL asynchronously force: state=IDLE, p=0, counter=0, cdcValid=0, reqReady=0, busy=0, grantId=0, cdcData=0.
REQ-028 A reset asserted mid-ISSUE or mid-WAIT SHALL abort without completing the launch; after reset release, the first grant SHALL follow REQ-020.

Verification
REQ-029 Single request: reset released, enable=1, reqValid=4'b0100, reqData[2]=32'hA5A5_0002 -> cycle k+1: cdcValid=1, reqReady=4'b0100, cdcData=32'hA5A5_0002, grantId=2; busy high for 17 cycles.
REQ-030 All requesting: reqValid=4'b1111 held continuously -> grant order 0,1,2,3,0, with cdcValid pulses exactly 18 cycles apart.
REQ-031 Pointer wrap: grant to 3, then reqValid=4'b1001 -> next grant is 0, then 3.
REQ-032 Enable gating: enable dropped during WAIT with reqValid=4'b0010 -> the current WAIT completes and no grant occurs; enable raised -> grant to 1 on the following cycle.
REQ-033 Reset mid-WAIT with counter=7 -> all outputs are 0 immediately; after release, reqValid=4'b0001 -> grant 0 per REQ-020.
REQ-034 Withdrawn request: requester 1 drops reqValid during its WAIT -> no second grant to 1; cdcData is held at the granted value.

Source files
------------

// File: rtl/ip_cdc_arb.sv
// Round-robin arbiter that feeds several requesters into one handshake CDC
// channel. Each launch is a single-cycle pulse, followed by an enforced quiet
// period so that the channel can finish its lock/release round trip.
module ip_cdc_arb #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   reqData,
    output logic [NUM_REQ-1:0]             reqReady,
    output logic                           cdcValid,
    output logic [DATAWIDTH-1:0]           cdcData,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grantId
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_next;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic [31:0]       rr_cand;
    logic              launch;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rr_cand = 32'(ptr) + 32'(i);
            if (rr_cand >= 32'(NUM_REQ)) begin
                rr_cand = rr_cand - 32'(NUM_REQ);
            end
            if (!win_found && reqValid[rr_cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = rr_cand[ID_W-1:0];
            end
        end
    end

    assign launch = (state == IDLE) && enable && win_found;

    // Pointer moves just past the winner.
    always_comb begin
        ptr_next = ptr;
        if (launch) begin
            if (win_id == ID_W'(NUM_REQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = win_id + ID_W'(1);
            end
        end
    end

    // Next-state and hold-counter logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = CNT_W'(HOLD_CYCLES - 1);
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and round-robin pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
        end
    end

    // Registered outputs; launch pulse and ready pulse line up with ISSUE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdcValid <= 1'b0;
            reqReady <= '0;
            busy     <= 1'b0;
            grantId  <= '0;
            cdcData  <= '0;
        end else begin
            cdcValid <= launch;
            reqReady <= launch ? (NUM_REQ'(1) << win_id) : '0;
            busy     <= (state_next != IDLE);
            if (launch) begin
                grantId <= win_id;
                cdcData <= reqData[32'(win_id) * DATAWIDTH +: DATAWIDTH];
            end
        end
    end

endmodule

// File: tb/tb_ip_cdc_arb.sv
// Bench for ip_cdc_arb: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_ip_cdc_arb;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int HOLD = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic [N-1:0]         reqValid = '0;
    logic [N*W-1:0]       reqData = '0;
    logic [N-1:0]         reqReady;
    logic                 cdcValid;
    logic [W-1:0]         cdcData;
    logic                 busy;
    logic [$clog2(N)-1:0] grantId;

    ip_cdc_arb #(.NUM_REQ(N), .DATAWIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqReady (reqReady),
        .cdcValid (cdcValid),
        .cdcData  (cdcData),
        .busy     (busy),
        .grantId  (grantId)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // Winner = the set requester with the smallest ascending distance from ptr.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        int best;
        best = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[(p + k) % N]) best = (p + k) % N;
        end
        return best;
    endfunction

    // Behavioural model: grants only when the previous launch's busy window is over.
    int           m_ptr;
    int           m_busy_left;
    logic         m_valid;
    logic [N-1:0] m_ready;
    logic [W-1:0] m_data;
    int           m_id;
    int           pick;

    assign pick = rr_pick(reqValid, m_ptr);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ptr <= 0; m_busy_left <= 0; m_valid <= 1'b0;
            m_ready <= '0; m_data <= '0; m_id <= 0;
        end else if (m_busy_left == 0 && enable && pick >= 0) begin
            m_id        <= pick;
            m_valid     <= 1'b1;
            m_ready     <= N'(1) << pick;
            m_data      <= reqData[pick * W +: W];
            m_ptr       <= (pick + 1) % N;
            m_busy_left <= HOLD + 1;
        end else begin
            m_valid <= 1'b0;
            m_ready <= '0;
            if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            check("cdcValid", 64'(cdcValid), 64'(m_valid));
            check("reqReady", 64'(reqReady), 64'(m_ready));
            check("busy",     64'(busy),     64'(m_busy_left != 0));
            check("grantId",  64'(grantId),  64'(m_id));
            check("cdcData",  64'(cdcData),  64'(m_data));
        end
    end

    task automatic wait_grant(input int limit, output int id, output int t);
        bit found;
        found = 1'b0;
        id = -1;
        t = 0;
        for (int c = 0; c < limit && !found; c++) begin
            @(negedge clock);
            if (cdcValid) begin
                found = 1'b1;
                id = int'(grantId);
                t = cycle;
            end
        end
        if (!found) begin
            n_checks++;
            $display("FAIL grant_timeout: no cdcValid within %0d cycles", limit);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cdcValid"}, 64'(cdcValid), 64'd0);
        check({tag, "_reqReady"}, 64'(reqReady), 64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_grantId"},  64'(grantId),  64'd0);
        check({tag, "_cdcData"},  64'(cdcData),  64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        reqValid = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int ids[5];
    int ts[5];
    int id, t, cnt, pulses;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        // Single request from requester 2.
        @(negedge clock);
        enable = 1'b1;
        reqValid = 4'b0100;
        reqData[2*W +: W] = 32'hA5A5_0002;
        @(negedge clock);
        check("single_cdcValid", 64'(cdcValid), 64'd1);
        check("single_reqReady", 64'(reqReady), 64'b0100);
        check("single_cdcData",  64'(cdcData),  64'hA5A5_0002);
        check("single_grantId",  64'(grantId),  64'd2);
        reqValid = '0;
        cnt = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (busy) cnt++;
            else break;
        end
        check("single_busy_len", 64'(cnt), 64'd17);

        // Everyone requesting from a fresh pointer.
        do_reset();
        for (int i = 0; i < N; i++) reqData[i*W +: W] = 32'h1000_0000 + 32'(i);
        reqValid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(40, id, t);
            ids[k] = id;
            ts[k] = t;
            if (id >= 0) reqData[id*W +: W] = 32'h2000_0000 + 32'(k);
        end
        reqValid = '0;
        for (int k = 0; k < 5; k++) check("all_order", 64'(ids[k]), 64'(exp_order[k]));
        for (int k = 1; k < 5; k++) check("all_spacing", 64'(ts[k] - ts[k-1]), 64'd18);

        // Pointer wrap: 3, then 0 before 3.
        reqValid = 4'b1000;
        reqData[3*W +: W] = 32'h3333_0003;
        wait_grant(40, id, t);
        check("wrap_first", 64'(id), 64'd3);
        reqValid = 4'b1001;
        reqData[0 +: W] = 32'h3333_0000;
        wait_grant(40, id, t);
        check("wrap_second", 64'(id), 64'd0);
        reqValid = 4'b1000;
        wait_grant(40, id, t);
        check("wrap_third", 64'(id), 64'd3);
        reqValid = '0;

        // Enable dropped during WAIT blocks the next grant only.
        repeat (3) @(negedge clock);
        enable = 1'b0;
        reqValid = 4'b0010;
        reqData[1*W +: W] = 32'h1111_0001;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (cdcValid) pulses++;
            if (!busy) break;
        end
        repeat (5) begin
            @(negedge clock);
            if (cdcValid) pulses++;
        end
        check("gate_no_grant", 64'(pulses), 64'd0);
        check("gate_idle_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        @(negedge clock);
        check("gate_cdcValid", 64'(cdcValid), 64'd1);
        check("gate_grantId",  64'(grantId),  64'd1);

        // Requester 1 re-requests, then withdraws during WAIT.
        reqData[1*W +: W] = 32'h2222_0001;
        repeat (4) @(negedge clock);
        reqValid = '0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (cdcValid) pulses++;
        end
        check("withdraw_no_grant", 64'(pulses), 64'd0);
        check("withdraw_data", 64'(cdcData), 64'h1111_0001);
        check("withdraw_id",   64'(grantId), 64'd1);

        // Reset while the hold counter reads 7.
        reqValid = 4'b0100;
        reqData[2*W +: W] = 32'h4444_0002;
        wait_grant(40, id, t);
        reqValid = '0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_all_zero("midwait");
        @(negedge clock);
        reset = 1'b1;
        reqValid = 4'b0001;
        reqData[0 +: W] = 32'h5555_0000;
        @(negedge clock);
        check("postrst_cdcValid", 64'(cdcValid), 64'd1);
        check("postrst_grantId",  64'(grantId),  64'd0);
        check("postrst_reqReady", 64'(reqReady), 64'b0001);
        reqValid = '0;

        // Randomized requesters following the hold-until-ready protocol.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c == 1500) begin
                #($urandom_range(1, 4)) reset = 1'b0;
                @(negedge clock);
                @(negedge clock);
                reset = 1'b1;
            end
            enable = ($urandom % 10) != 0;
            for (int i = 0; i < N; i++) begin
                if (reqValid[i] && reqReady[i]) begin
                    if ($urandom % 2 == 0) begin
                        reqData[i*W +: W] = $urandom;
                    end else begin
                        reqValid[i] = 1'b0;
                    end
                end else if (!reqValid[i]) begin
                    if ($urandom % 4 == 0) begin
                        reqValid[i] = 1'b1;
                        reqData[i*W +: W] = $urandom;
                    end
                end else if ($urandom % 50 == 0) begin
                    reqValid[i] = 1'b0;
                end
            end
        end

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
